shader_prog_loader: RTL and testbench
=====================================

Name: shader_prog_loader

Overview:
Sequences writes from the SPI command byte stream into the tiny shader instruction memory.
- Parses framed commands and buffers {addr, data, sync} entries in a small FIFO.
- Commits entries only on cycles when the shader is not fetching.
- Sync writes are held until the next frame boundary, so a program swap never tears mid-frame.
- Sits between the SPI byte receiver and the instruction memory write port inside tiny_shader_top.

Parameters:
ADDR_W, 4, instruction memory address width (2^ADDR_W instructions)
INSTR_W, 8, instruction width; must equal 8 (one command byte per instruction)
FIFO_DEPTH, 4, staging FIFO entries; power of two, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cmd_start_i  in  1  pulse: the next accepted byte is the first byte of a new SPI frame (CS fell)
cmd_valid_i  in  1  byte valid from SPI receiver
cmd_data_i  in  8  byte payload
cmd_ready_o  out  1  byte accepted when cmd_valid_i && cmd_ready_o
next_frame_i  in  1  one-cycle frame-boundary pulse from the timing generator
shader_active_i  in  1  high while the shader reads instruction memory this cycle
instr_we_o  out  1  instruction memory write enable (registered)
instr_addr_o  out  ADDR_W  write address (registered)
instr_data_o  out  INSTR_W  write data (registered)
busy_o  out  1  FIFO non-empty or a sync entry is waiting
err_o  out  1  sticky: unknown command seen; cleared by reset only

Behaviour:
- Reset: all outputs 0; FSM PARSE_CMD; FIFO empty; frame_armed_q=0; address counter 0.
- Commands (first byte of frame): 0x01 WRITE_IMM, 0x02 WRITE_SYNC, other values set err_o and go to SKIP.
- Parse FSM:
  - PARSE_CMD -(valid cmd)-> PARSE_ADDR
  - PARSE_ADDR: byte[ADDR_W-1:0] loads the address counter -> PARSE_DATA
  - PARSE_DATA: each byte pushes {addr, byte, sync}, then addr increments modulo 2^ADDR_W (wraps silently); stays until the next cmd_start_i.
  - SKIP: discards bytes until cmd_start_i.
- cmd_start_i forces the byte accepted with it (or the next accepted byte) to be parsed as a command, from any state. Already-pushed entries are retained.
- cmd_ready_o = !fifo_full, combinational from FIFO state. In PARSE_CMD, PARSE_ADDR and SKIP, ready is also gated by fifo_full for simplicity.
- Commit: head pops when !fifo_empty && !shader_active_i && (!head.sync || frame_armed_q). The pop registers instr_we_o/addr/data for exactly one cycle.
- Latency: data byte accepted in cycle N, FIFO empty, shader idle -> instr_we_o=1 in cycle N+2.
- frame_armed_q:
  - set on next_frame_i;
  - cleared on a cycle where the FIFO is empty at cycle start and next_frame_i=0.
  - Sync entries pushed after the drain therefore wait for the following frame.
- Ordering: strictly FIFO. An IMM entry behind a waiting SYNC entry also waits (no reordering).
- Full FIFO with a simultaneous pop: ready stays low that cycle (no push); the freed slot is visible next cycle.
- busy_o = !fifo_empty.
- shader_active_i high blocks commit indefinitely; no timeout.
- Reset mid-operation: FIFO contents discarded; any in-flight instr_we_o drops asynchronously.

Optional Feature:
SHADER_LOADER_CHECKSUM_EN
- Defined: adds output checksum_o[7:0], the XOR of all instr_data_o values committed since the last accepted command byte. Cleared to 0 on reset and on each accepted command byte; updated the cycle after instr_we_o.
- Undefined: port and logic absent.

Decomposition:
- Package shader_loader_pkg: command opcode constants (CMD_WRITE_IMM=8'h01, CMD_WRITE_SYNC=8'h02), parse FSM state enum, FIFO entry struct typedef {sync, addr, data}.
- One sub-module: shader_loader_fifo, a synchronous FIFO with push/pop/full/empty, FIFO_DEPTH entries, async active-high reset.

Test Plan:
- IMM write: start, bytes 01,03,AA,BB, shader idle -> writes (3,AA) then (4,BB); first instr_we_o 2 cycles after AA accepted.
- SYNC hold: start, 02,00,11 -> no write; after next_frame_i pulse -> single write (0,11), busy_o falls.
- Address wrap: start, 01,0F,C1,C2 -> writes (15,C1),(0,C2).
- Backpressure: shader_active_i=1, stream 01,00 + 5 data bytes with FIFO_DEPTH=4 -> cmd_ready_o low after 4th data byte; release -> 5 in-order writes, no loss.
- Bad command: start, 7E,12,34 -> no writes, err_o=1; then start, 01,02,55 -> write (2,55), err_o stays 1.
- Reset mid-drain: 3 entries queued, shader active, assert rst_i -> outputs 0 immediately; after release no writes occur.

Source files
------------

// File: rtl/shader_loader_pkg.sv
// Shared types for the shader program loader: command opcodes, parse states
// and the staging FIFO entry layout.
package shader_loader_pkg;

  localparam logic [7:0] CMD_WRITE_IMM  = 8'h01;
  localparam logic [7:0] CMD_WRITE_SYNC = 8'h02;

  // Entry address field is sized for the largest supported memory (ADDR_W <= 8).
  localparam int ENTRY_ADDR_W = 8;

  typedef enum logic [1:0] {
    PARSE_CMD,
    PARSE_ADDR,
    PARSE_DATA,
    SKIP
  } parse_state_t;

  typedef struct packed {
    logic                    sync;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } fifo_entry_t;

endpackage

// File: rtl/shader_loader_fifo.sv
// Small synchronous staging FIFO of loader entries with a look-ahead head
// output; pointers carry an extra wrap bit to tell full from empty.
module shader_loader_fifo
  import shader_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_reg;
  logic [PTR_W:0] rd_ptr_reg;
  fifo_entry_t    mem [DEPTH];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                 (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign head  = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr_reg[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/shader_prog_loader.sv
// Parses framed SPI command bytes into instruction-memory writes, committing
// only while the shader is idle; sync writes wait for a frame boundary.
// Optional build macro SHADER_LOADER_CHECKSUM_EN adds checksum_o.
module shader_prog_loader
  import shader_loader_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int INSTR_W    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_start_i,
  input  logic               cmd_valid_i,
  input  logic [7:0]         cmd_data_i,
  output logic               cmd_ready_o,
  input  logic               next_frame_i,
  input  logic               shader_active_i,
  output logic               instr_we_o,
  output logic [ADDR_W-1:0]  instr_addr_o,
  output logic [INSTR_W-1:0] instr_data_o,
  output logic               busy_o,
  output logic               err_o
`ifdef SHADER_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         checksum_o
`endif
);

  parse_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              sync_reg, sync_next;
  logic              err_reg, err_next;
  logic              start_pending_reg, start_pending_next;
  logic              frame_armed_reg;
  logic              fifo_full, fifo_empty;
  logic              accept, is_cmd, push, pop;
  fifo_entry_t       push_entry, head;
  logic              unused_head_addr;

  assign cmd_ready_o = !fifo_full;
  assign accept      = cmd_valid_i && cmd_ready_o;
  // A start pulse may arrive while the byte is stalled; remember it until accepted.
  assign is_cmd      = cmd_start_i || start_pending_reg || (state_reg == PARSE_CMD);

  always_comb begin
    state_next         = state_reg;
    addr_next          = addr_reg;
    sync_next          = sync_reg;
    err_next           = err_reg;
    start_pending_next = start_pending_reg;
    push               = 1'b0;
    if (cmd_start_i && !accept)
      start_pending_next = 1'b1;
    if (accept) begin
      start_pending_next = 1'b0;
      if (is_cmd) begin
        if (cmd_data_i == CMD_WRITE_IMM || cmd_data_i == CMD_WRITE_SYNC) begin
          state_next = PARSE_ADDR;
          sync_next  = (cmd_data_i == CMD_WRITE_SYNC);
        end else begin
          state_next = SKIP;
          err_next   = 1'b1;
        end
      end else begin
        case (state_reg)
          PARSE_ADDR: begin
            addr_next  = cmd_data_i[ADDR_W-1:0];
            state_next = PARSE_DATA;
          end
          PARSE_DATA: begin
            push      = 1'b1;
            addr_next = addr_reg + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= PARSE_CMD;
      addr_reg          <= '0;
      sync_reg          <= 1'b0;
      err_reg           <= 1'b0;
      start_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      addr_reg          <= addr_next;
      sync_reg          <= sync_next;
      err_reg           <= err_next;
      start_pending_reg <= start_pending_next;
    end
  end

  assign push_entry.sync = sync_reg;
  assign push_entry.addr = ENTRY_ADDR_W'(addr_reg);
  assign push_entry.data = cmd_data_i;

  shader_loader_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Strict FIFO order: a held sync head also blocks any entry behind it.
  assign pop = !fifo_empty && !shader_active_i && (!head.sync || frame_armed_reg);
  assign unused_head_addr = ^head.addr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_armed_reg <= 1'b0;
      instr_we_o      <= 1'b0;
      instr_addr_o    <= '0;
      instr_data_o    <= '0;
    end else begin
      if (next_frame_i)
        frame_armed_reg <= 1'b1;
      else if (fifo_empty)
        frame_armed_reg <= 1'b0;
      instr_we_o <= pop;
      if (pop) begin
        instr_addr_o <= head.addr[ADDR_W-1:0];
        instr_data_o <= INSTR_W'(head.data);
      end
    end
  end

  assign busy_o = !fifo_empty;
  assign err_o  = err_reg;

`ifdef SHADER_LOADER_CHECKSUM_EN
  logic [7:0] checksum_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      checksum_reg <= '0;
    else if (accept && is_cmd)
      checksum_reg <= '0;
    else if (instr_we_o)
      checksum_reg <= checksum_reg ^ 8'(instr_data_o);
  end

  assign checksum_o = checksum_reg;
`endif

endmodule

// File: tb/tb_shader_prog_loader.sv
// Directed self-checking bench for shader_prog_loader (default build).
module tb_shader_prog_loader;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_start_i = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ready_o;
  logic       next_frame_i = 1'b0;
  logic       shader_active_i = 1'b0;
  logic       instr_we_o;
  logic [3:0] instr_addr_o;
  logic [7:0] instr_data_o;
  logic       busy_o;
  logic       err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] wr_q[$];

  shader_prog_loader #(.ADDR_W(4), .INSTR_W(8), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cmd_start_i    (cmd_start_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_data_i     (cmd_data_i),
    .cmd_ready_o    (cmd_ready_o),
    .next_frame_i   (next_frame_i),
    .shader_active_i(shader_active_i),
    .instr_we_o     (instr_we_o),
    .instr_addr_o   (instr_addr_o),
    .instr_data_o   (instr_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every committed write as {addr, data}.
  always @(posedge clk_i) begin
    if (instr_we_o)
      wr_q.push_back({instr_addr_o, instr_data_o});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send(input logic [7:0] b, input logic st);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_data_i  = b;
    cmd_start_i = st;
    #1;
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (n >= 50) check("send_timeout", 32'(cmd_ready_o), 32'h1);
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_start_i = 1'b0;
  endtask

  function automatic logic [11:0] q_at(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 12'hxxx;
  endfunction

  initial begin
    // Reset state
    wait_cycles(2);
    check("rst_we", 32'(instr_we_o), 32'h0);
    check("rst_addr", 32'(instr_addr_o), 32'h0);
    check("rst_data", 32'(instr_data_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_ready", 32'(cmd_ready_o), 32'h1);
    rst_i = 1'b0;
    wait_cycles(1);

    // IMM write with latency check
    send(8'h01, 1'b1);
    send(8'h03, 1'b0);
    send(8'hAA, 1'b0);
    check("imm_lat_n1", 32'(instr_we_o), 32'h0);
    send(8'hBB, 1'b0);
    check("imm_we0", 32'(instr_we_o), 32'h1);
    check("imm_wr0", 32'({instr_addr_o, instr_data_o}), 32'h3AA);
    wait_cycles(1);
    check("imm_we1", 32'(instr_we_o), 32'h1);
    check("imm_wr1", 32'({instr_addr_o, instr_data_o}), 32'h4BB);
    wait_cycles(1);
    check("imm_we_off", 32'(instr_we_o), 32'h0);
    check("imm_busy", 32'(busy_o), 32'h0);
    wr_q.delete();

    // SYNC hold until frame boundary
    send(8'h02, 1'b1);
    send(8'h00, 1'b0);
    send(8'h11, 1'b0);
    wait_cycles(5);
    check("sync_held", 32'(wr_q.size()), 32'h0);
    check("sync_busy", 32'(busy_o), 32'h1);
    next_frame_i = 1'b1;
    wait_cycles(1);
    next_frame_i = 1'b0;
    wait_cycles(3);
    check("sync_count", 32'(wr_q.size()), 32'h1);
    check("sync_wr", 32'(q_at(0)), 32'h011);
    check("sync_busy_off", 32'(busy_o), 32'h0);
    wr_q.delete();

    // Address wrap
    send(8'h01, 1'b1);
    send(8'h0F, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    wait_cycles(4);
    check("wrap_count", 32'(wr_q.size()), 32'h2);
    check("wrap_wr0", 32'(q_at(0)), 32'hFC1);
    check("wrap_wr1", 32'(q_at(1)), 32'h0C2);
    wr_q.delete();

    // Backpressure: FIFO fills while shader is active
    shader_active_i = 1'b1;
    send(8'h01, 1'b1);
    send(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hD0 + 8'(i), 1'b0);
    check("bp_ready_full", 32'(cmd_ready_o), 32'h0);
    check("bp_busy", 32'(busy_o), 32'h1);
    cmd_valid_i = 1'b1;
    cmd_data_i  = 8'hD4;
    wait_cycles(1);
    check("bp_ready_hold", 32'(cmd_ready_o), 32'h0);
    check("bp_no_write", 32'(wr_q.size()), 32'h0);
    shader_active_i = 1'b0;
    send(8'hD4, 1'b0);
    wait_cycles(10);
    check("bp_count", 32'(wr_q.size()), 32'h5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bp_wr%0d", i), 32'(q_at(i)), 32'({4'(i), 8'hD0 + 8'(i)}));
    wr_q.delete();

    // Unknown command
    send(8'h7E, 1'b1);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    wait_cycles(3);
    check("bad_err", 32'(err_o), 32'h1);
    check("bad_no_write", 32'(wr_q.size()), 32'h0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h55, 1'b0);
    wait_cycles(4);
    check("bad_rec_count", 32'(wr_q.size()), 32'h1);
    check("bad_rec_wr", 32'(q_at(0)), 32'h255);
    check("bad_err_sticky", 32'(err_o), 32'h1);
    wr_q.delete();

    // Reset mid-drain with a write in flight
    shader_active_i = 1'b1;
    send(8'h01, 1'b1);
    send(8'h05, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    check("rd_busy", 32'(busy_o), 32'h1);
    shader_active_i = 1'b0;
    wait_cycles(1);
    shader_active_i = 1'b1;
    check("rd_inflight", 32'({instr_we_o, instr_addr_o, instr_data_o}), 32'h15A1);
    #2 rst_i = 1'b1;
    #1;
    check("rd_we_async", 32'(instr_we_o), 32'h0);
    check("rd_addr_async", 32'(instr_addr_o), 32'h0);
    check("rd_data_async", 32'(instr_data_o), 32'h0);
    check("rd_busy_async", 32'(busy_o), 32'h0);
    check("rd_err_clr", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    shader_active_i = 1'b0;
    wait_cycles(6);
    check("rd_no_write", 32'(wr_q.size()), 32'h0);
    check("rd_busy_after", 32'(busy_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
